// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample path.
package audio_pkg;

    localparam int AUDIO_W = 8;
    localparam logic [AUDIO_W-1:0] DC_MID = 8'd128;

    // Serial ADC frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } adc_state_e;

    // Distance from mid-scale, doubled to use the full 8-bit range; the
    // single out-of-range case (code 0, distance 128) saturates to full scale.
    function automatic logic [AUDIO_W-1:0] dc_remove(input logic [AUDIO_W-1:0] raw);
        logic [AUDIO_W-1:0] mag;
        if (raw >= DC_MID) begin
            mag = raw - DC_MID;
        end else begin
            mag = DC_MID - raw;
        end
        if (mag == DC_MID) begin
            return '1;
        end
        return {mag[AUDIO_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/adc_sample_source_if.sv
// Sample stream from the ADC reader to the dB calculator.
interface adc_sample_source_if;
    import audio_pkg::*;

    logic [AUDIO_W-1:0] audio_data;
    logic               audio_valid;
    logic               sample_miss;

    modport master (output audio_data, audio_valid, sample_miss);
    modport slave  (input  audio_data, audio_valid, sample_miss);

endinterface

// File: rtl/adc_sample_source_sync_2ff.sv
// 1-bit double-flop synchronizer for asynchronous inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronisation into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_sample_source.sv
// Periodic TLC549-class serial ADC reader producing the audio sample stream.
module adc_sample_source
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int SAMPLE_DIV = 1250,
    parameter bit REMOVE_DC  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic                       adc_cs_n,
    output logic                       adc_sclk,
    input  logic                       adc_dout,
    adc_sample_source_if.master        aud
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int PH_W   = $clog2(CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic               dout_sync;

    adc_state_e         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [AUDIO_W-1:0] shift_q, shift_d;
    logic               phase_last;

    logic               cs_n_q;
    logic               sclk_q;
    logic [AUDIO_W-1:0] data_q;
    logic               valid_q;
    logic               miss_q;
    logic [AUDIO_W-1:0] conv;

    sync_2ff u_dout_sync (
        .clk (clk),
        .rst (rst),
        .d_i (adc_dout),
        .q_o (dout_sync)
    );

    // Sample-rate tick: free-running while enabled, parked at zero otherwise
    always_comb begin
        tick       = enable && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (!enable || tick) begin
            tick_cnt_d = '0;
        end
    end

    // Frame sequencer next-state: SCLK phases and MSB-first bit capture
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        phase_last = (phase_q == PH_LAST);
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d   = ST_SETUP;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_last) begin
                    shift_d   = {shift_q[AUDIO_W-2:0], dout_sync};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    phase_d   = '0;
                    state_d   = ST_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = (bit_cnt_q == 4'd8) ? ST_DONE : ST_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output code for the completed frame
    always_comb begin
        conv = shift_q;
        if (REMOVE_DC) begin
            conv = dc_remove(shift_q);
        end
    end

    // Sequencer and tick state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Registered pin and stream outputs, decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            cs_n_q  <= !(state_d inside {ST_SETUP, ST_HIGH, ST_LOW});
            sclk_q  <= (state_d == ST_HIGH);
            valid_q <= (state_d == ST_DONE);
            miss_q  <= tick && (state_q != ST_IDLE);
            if (state_d == ST_DONE) begin
                data_q <= conv;
            end
        end
    end

    assign adc_cs_n        = cs_n_q;
    assign adc_sclk        = sclk_q;
    assign aud.audio_data  = data_q;
    assign aud.audio_valid = valid_q;
    assign aud.sample_miss = miss_q;

endmodule
